fp_add_sched: RTL and testbench

Two-port issue scheduler for the shared single-precision `fp_add` pipeline. It arbitrates round-robin between two valid/ready requesters and drives the operands into `fp_add`. A tag shift register tracks each operation through the fixed-latency pipeline. Results are buffered in a credit-protected response FIFO, so the non-stallable `fp_add` never loses a result under downstream back-pressure. It sits beside `fp_add` in the top level; the `fp_add` instance stays outside the block.

---
 rtl/fp_sched_pkg.sv | 15 +
 rtl/rsp_fifo.sv | 57 +++++
 rtl/fp_add_sched.sv | 146 ++++++++++++++
 tb/tb_fp_add_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sched_pkg.sv
// rtl/fp_sched_pkg.sv - shared widths and response record for the fp_add issue scheduler
package fp_sched_pkg;

  localparam int WORD_W      = 32;
  localparam int DEFAULT_LAT = 7;
  localparam int RSP_TAG_W   = 4;

  // One buffered response: originating requester, its tag and the sum.
  typedef struct packed {
    logic                 src;
    logic [RSP_TAG_W-1:0] tag;
    logic [WORD_W-1:0]    data;
  } rsp_t;

endpackage

// File: rtl/rsp_fifo.sv
// rtl/rsp_fifo.sv - synchronous first-word-fall-through response FIFO with occupancy count
module rsp_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // At full a simultaneous pop frees the head slot that the write lands in.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Credits bound the in-flight work, so a push can never meet a full FIFO.
  no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/fp_add_sched.sv
// rtl/fp_add_sched.sv - round-robin two-port issue scheduler for the shared fp_add pipeline
module fp_add_sched
  import fp_sched_pkg::*;
#(
  parameter int LAT        = DEFAULT_LAT,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WORD_W-1:0] req0_a,
  input  logic [WORD_W-1:0] req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WORD_W-1:0] req1_a,
  input  logic [WORD_W-1:0] req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic [WORD_W-1:0] fpa_dataa,
  output logic [WORD_W-1:0] fpa_datab,
  input  logic [WORD_W-1:0] fpa_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_src,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + TAG_W + WORD_W;

  logic [CW-1:0]     cred;
  logic              last;
  logic              grant0;
  logic              grant1;
  logic              has_cred;
  logic              hs0;
  logic              hs1;
  logic              issue;
  logic              pop;

  logic              iss_v;
  logic              iss_src;
  logic [TAG_W-1:0]  iss_tag;
  logic [WORD_W-1:0] iss_a;
  logic [WORD_W-1:0] iss_b;

  logic [LAT-1:0]    pipe_v;
  logic [LAT-1:0]    pipe_src;
  logic [TAG_W-1:0]  pipe_tag [LAT];

  logic [EW-1:0]     head;
  logic [AW:0]       fifo_count;
  logic              fifo_nonempty;

  // Round-robin grant: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant0   = req0_valid & (~req1_valid | last);
    grant1   = req1_valid & (~req0_valid | ~last);
    has_cred = (cred != '0);
  end

  assign req0_ready = ~reset & grant0 & has_cred;
  assign req1_ready = ~reset & grant1 & has_cred;
  assign hs0        = req0_valid & req0_ready;
  assign hs1        = req1_valid & req1_ready;
  assign issue      = hs0 | hs1;

  // Credits count free FIFO slots not yet claimed by an in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      cred <= CW'(FIFO_DEPTH);
      last <= 1'b1;
    end else begin
      if (issue & ~pop)      cred <= cred - 1'b1;
      else if (pop & ~issue) cred <= cred + 1'b1;
      if (hs0)      last <= 1'b0;
      else if (hs1) last <= 1'b1;
    end
  end

  // Issue register drives fp_add; idle cycles present zero operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      iss_v   <= 1'b0;
      iss_src <= 1'b0;
      iss_tag <= '0;
      iss_a   <= '0;
      iss_b   <= '0;
    end else begin
      iss_v   <= issue;
      iss_src <= hs1;
      iss_tag <= hs1 ? req1_tag : (hs0 ? req0_tag : '0);
      iss_a   <= hs1 ? req1_a   : (hs0 ? req0_a   : '0);
      iss_b   <= hs1 ? req1_b   : (hs0 ? req0_b   : '0);
    end
  end

  // Valid bits of the tag pipe; clearing them drops results already inside fp_add.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= iss_v;
      for (int i = 1; i < LAT; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  // Source and tag ride alongside the valids so the last stage lines up with fpa_result.
  always_ff @(posedge clk) begin
    pipe_src[0] <= iss_src;
    pipe_tag[0] <= iss_tag;
    for (int i = 1; i < LAT; i++) begin
      pipe_src[i] <= pipe_src[i-1];
      pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  rsp_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pipe_v[LAT-1]),
    .push_data ({pipe_src[LAT-1], pipe_tag[LAT-1], fpa_result}),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign fifo_nonempty = (fifo_count != '0);
  assign rsp_valid     = ~reset & fifo_nonempty;
  assign pop           = rsp_valid & rsp_ready;
  assign rsp_data      = rsp_valid ? head[WORD_W-1:0] : '0;
  assign rsp_tag       = rsp_valid ? head[WORD_W +: TAG_W] : '0;
  assign rsp_src       = rsp_valid & head[EW-1];
  assign fpa_dataa     = reset ? '0 : iss_a;
  assign fpa_datab     = reset ? '0 : iss_b;
  assign busy          = ~reset & (iss_v | (|pipe_v) | fifo_nonempty);

endmodule

// File: tb/tb_fp_add_sched.sv
// tb/tb_fp_add_sched.sv - scoreboard bench for fp_add_sched with a behavioural fp_add
module tb_fp_add_sched;
  import fp_sched_pkg::*;

  localparam int LAT        = 7;
  localparam int FIFO_DEPTH = 8;
  localparam int TAG_W      = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_tag, req1_tag;
  logic [31:0] fpa_dataa, fpa_datab, fpa_result;
  logic        rsp_valid, rsp_ready, rsp_src, busy;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int x0, y0, x1, y1;

  rsp_t exp_q[$];
  int   iss_cq[$];
  int   hs_cyc[$];
  int   hs_log[$];
  int   pop_cyc[$];
  int   last_lat;
  logic [31:0] last_data;
  logic        last_src, last_busy;
  logic [3:0]  last_tag;

  logic        p0_pend = 1'b0, p1_pend = 1'b0;
  logic [67:0] p0_pay, p1_pay;

  fp_add_sched #(.LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .fpa_dataa(fpa_dataa), .fpa_datab(fpa_datab), .fpa_result(fpa_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_src(rsp_src),
    .rsp_tag(rsp_tag), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Operands are integer-valued floats, so the sum is exact and easy to model.
  function automatic logic [31:0] int_to_f32(input int n);
    int mag;
    int msb;
    logic [31:0] sh;
    if (n == 0) return 32'd0;
    mag = (n < 0) ? -n : n;
    msb = 0;
    for (int i = 0; i < 31; i++) if (mag[i]) msb = i;
    sh = 32'(mag) << (23 - msb);
    return {(n < 0), 8'(127 + msb), sh[22:0]};
  endfunction

  function automatic int f32_to_int(input logic [31:0] f);
    int e;
    int m;
    e = int'(f[30:23]) - 127;
    if (f[30:23] == 8'd0 || e < 0 || e > 23) return 0;
    m = {8'd0, 1'b1, f[22:0]} >> (23 - e);
    return f[31] ? -m : m;
  endfunction

  function automatic int rand_val();
    return int'($urandom_range(0, 2097152)) - 1048576;
  endfunction

  // Behavioural fp_add: fixed LAT-cycle pipeline, non-stallable.
  logic [31:0] fpa_pipe [LAT];
  always @(posedge clk) begin
    fpa_pipe[0] <= int_to_f32(f32_to_int(fpa_dataa) + f32_to_int(fpa_datab));
    for (int i = 1; i < LAT; i++) fpa_pipe[i] <= fpa_pipe[i-1];
  end
  assign fpa_result = fpa_pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: records handshakes into the scoreboard and checks every popped response.
  always @(negedge clk) begin
    rsp_t e;
    int   ic;
    if (reset) begin
      exp_q.delete();
      iss_cq.delete();
      p0_pend = 1'b0;
      p1_pend = 1'b0;
    end else begin
      if (p0_pend && !(req0_valid && {req0_a, req0_b, req0_tag} == p0_pay)) begin
        checks++; errors++;
        $display("FAIL req0_hold: valid/payload changed before handshake (cycle %0d)", cyc);
      end
      if (p1_pend && !(req1_valid && {req1_a, req1_b, req1_tag} == p1_pay)) begin
        checks++; errors++;
        $display("FAIL req1_hold: valid/payload changed before handshake (cycle %0d)", cyc);
      end
      if (req0_ready || req1_ready) begin
        chk("one_ready", 64'(req0_ready & req1_ready), 64'd0);
        chk("ready_without_valid", 64'((req0_ready & ~req0_valid) | (req1_ready & ~req1_valid)), 64'd0);
      end
      if (req0_valid && req0_ready) begin
        e.src = 1'b0; e.tag = req0_tag; e.data = int_to_f32(x0 + y0);
        exp_q.push_back(e); iss_cq.push_back(cyc); hs_cyc.push_back(cyc); hs_log.push_back(0);
      end else if (req1_valid && req1_ready) begin
        e.src = 1'b1; e.tag = req1_tag; e.data = int_to_f32(x1 + y1);
        exp_q.push_back(e); iss_cq.push_back(cyc); hs_cyc.push_back(cyc); hs_log.push_back(1);
      end
      p0_pend = req0_valid & ~req0_ready;
      p1_pend = req1_valid & ~req1_ready;
      p0_pay  = {req0_a, req0_b, req0_tag};
      p1_pay  = {req1_a, req1_b, req1_tag};
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: data 0x%0h with empty scoreboard (cycle %0d)", rsp_data, cyc);
        end else begin
          e  = exp_q.pop_front();
          ic = iss_cq.pop_front();
          chk("rsp_data", 64'(rsp_data), 64'(e.data));
          chk("rsp_src", 64'(rsp_src), 64'(e.src));
          chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
          last_lat  = cyc - ic;
          last_data = rsp_data;
          last_src  = rsp_src;
          last_tag  = rsp_tag;
          last_busy = busy;
        end
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Drive one request and hold it stable until the handshake edge.
  task automatic send(input int r, input int x, input int y, input logic [3:0] tag);
    int n = 0;
    if (r == 0) begin
      req0_a = int_to_f32(x); req0_b = int_to_f32(y); req0_tag = tag; x0 = x; y0 = y; req0_valid = 1'b1;
    end else begin
      req1_a = int_to_f32(x); req1_b = int_to_f32(y); req1_tag = tag; x1 = x; y1 = y; req1_valid = 1'b1;
    end
    forever begin
      @(negedge clk);
      if (r == 0 ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) break;
      n++;
      if (n > 400) begin
        checks++; errors++;
        $display("FAIL send_timeout: req%0d no handshake within 400 cycles", r);
        break;
      end
    end
    @(posedge clk); #1;
    if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target, input int bound);
    int n = 0;
    while (hs_cyc.size() < target) begin
      @(posedge clk); #2;
      n++;
      if (n > bound) begin
        checks++; errors++;
        $display("FAIL wait_hs_timeout: %0d handshakes, required %0d", hs_cyc.size(), target);
        break;
      end
    end
  endtask

  task automatic wait_pops(input int target, input int bound);
    int n = 0;
    while (pop_cyc.size() < target) begin
      @(posedge clk); #2;
      n++;
      if (n > bound) begin
        checks++; errors++;
        $display("FAIL wait_pop_timeout: %0d pops, required %0d", pop_cyc.size(), target);
        break;
      end
    end
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 || busy) begin
      @(posedge clk); #2;
      n++;
      if (n > bound) begin
        checks++; errors++;
        $display("FAIL drain_timeout: %0d responses outstanding, busy %0b", exp_q.size(), busy);
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Fill the FIFO with rsp_ready low, then release and check credit-driven resumption.
  task automatic fill_test(input int r, input int nops);
    int hb, pb;
    rsp_ready = 1'b0;
    hb = hs_cyc.size();
    pb = pop_cyc.size();
    fork
      for (int i = 0; i < nops; i++) send(r, rand_val(), rand_val(), 4'(i));
    join_none
    repeat (30) @(posedge clk);
    #2 chk("fill_accept_count", 64'(hs_cyc.size() - hb), 64'(FIFO_DEPTH));
    @(negedge clk);
    chk("fill_ready_low", 64'(r == 0 ? req0_ready : req1_ready), 64'd0);
    chk("fill_valid_waiting", 64'(r == 0 ? req0_valid : req1_valid), 64'd1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_pops(pb + 1, 50);
    wait_hs(hb + nops, 200);
    if (hs_cyc.size() >= hb + nops && pop_cyc.size() > pb) begin
      chk("resume_after_pop", 64'(hs_cyc[hb + FIFO_DEPTH] - pop_cyc[pb]), 64'd1);
      for (int i = 1; i < nops - FIFO_DEPTH && i < FIFO_DEPTH; i++)
        chk("issue_with_pop", 64'(hs_cyc[hb + FIFO_DEPTH + i] - hs_cyc[hb + FIFO_DEPTH]), 64'(i));
    end
    wait_drain(200);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int hb, pb, quiet, stop;
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'h3F800000; req0_b = 32'h3F800000; req0_tag = 4'd3;
    req1_a = 32'h40000000; req1_b = 32'h40000000; req1_tag = 4'd7;
    x0 = 1; y0 = 1; x1 = 2; y1 = 2;

    // Reset state, with both valids raised to prove readies are held off.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req0_ready", 64'(req0_ready), 64'd0);
    chk("reset_req1_ready", 64'(req1_ready), 64'd0);
    chk("reset_fpa_dataa", 64'(fpa_dataa), 64'd0);
    chk("reset_fpa_datab", 64'(fpa_datab), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    chk("reset_rsp_src", 64'(rsp_src), 64'd0);
    chk("reset_rsp_tag", 64'(rsp_tag), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

    // Single op: 1.0 + 2.0 from req0 with tag 5.
    pb = pop_cyc.size();
    send(0, 1, 2, 4'd5);
    wait_pops(pb + 1, 40);
    chk("single_latency", 64'(last_lat), 64'(LAT + 2));
    chk("single_data", 64'(last_data), 64'h40400000);
    chk("single_src", 64'(last_src), 64'd0);
    chk("single_tag", 64'(last_tag), 64'd5);
    chk("single_busy_at_pop", 64'(last_busy), 64'd1);
    @(negedge clk);
    chk("single_busy_after_pop", 64'(busy), 64'd0);

    // Both requesters contending: grants alternate starting with req0.
    do_reset();
    hb = hs_cyc.size();
    fork
      for (int i = 0; i < 8; i++) send(0, rand_val(), rand_val(), 4'(i));
      for (int i = 0; i < 8; i++) send(1, rand_val(), rand_val(), 4'(i + 8));
    join
    wait_drain(100);
    if (hs_log.size() >= hb + 16) begin
      for (int i = 0; i < 16; i++) chk("alternate_grant", 64'(hs_log[hb + i]), 64'(i % 2));
      for (int i = 1; i < FIFO_DEPTH; i++) chk("back_to_back_issue", 64'(hs_cyc[hb + i] - hs_cyc[hb]), 64'(i));
    end

    // Back-pressure: credits cap acceptance at the FIFO depth.
    fill_test(0, 10);
    fill_test(1, 16);

    // Reset with 3 results buffered and 5 operations still inside fp_add.
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(0, rand_val(), rand_val(), 4'(i));
    repeat (LAT + 5) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send(1, rand_val(), rand_val(), 4'(i + 3));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_rsp_data", 64'(rsp_data), 64'd0);
    chk("midreset_fpa_dataa", 64'(fpa_dataa), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("postreset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("postreset_busy", 64'(busy), 64'd0);
    quiet = 0;
    for (int i = 0; i < LAT + 8; i++) begin
      @(negedge clk);
      if (rsp_valid) quiet++;
    end
    chk("stale_results_dropped", 64'(quiet), 64'd0);
    fill_test(0, 10);

    // Random traffic against the scoreboard.
    hb = hs_cyc.size();
    pb = pop_cyc.size();
    stop = cyc + 10000;
    fork
      while (cyc < stop) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        send(0, rand_val(), rand_val(), 4'($urandom_range(0, 15)));
      end
      while (cyc < stop) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        send(1, rand_val(), rand_val(), 4'($urandom_range(0, 15)));
      end
      while (cyc < stop) begin
        @(posedge clk); #1;
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    join
    rsp_ready = 1'b1;
    wait_drain(300);
    chk("random_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("random_all_returned", 64'(pop_cyc.size() - pb), 64'(hs_cyc.size() - hb));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
